mac_result_serializer: RTL and testbench

- Consumer end of the MAC datapath: accepts one DATA_W-bit accumulated result per valid/ready handshake and transmits it on a single-wire, UART-style frame.
- Frame format: start bit, data bits MSB-first, optional parity bit, stop bit.
- Sits between the mac output and a board pin or logic-analyser probe so results can be read without a simulator.

---
 rtl/mac_pkg.sv | 25 ++
 rtl/mac_result_serializer_if.sv | 11 +
 rtl/mac_ser_baud_div.sv | 31 +++
 rtl/mac_result_serializer.sv | 157 +++++++++++++++
 tb/tb_mac_result_serializer.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC result path: output width, serializer state
// encoding and a constant clog2 helper.
package mac_pkg;

  localparam int unsigned MAC_OUT_W = 18;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } ser_state_e;

  // Ceiling log2 for elaboration-time width calculations.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_result_serializer_if.sv
// Valid/ready word handshake between the MAC output and the serializer.
interface mac_result_serializer_if #(
  parameter int unsigned DATA_W = mac_pkg::MAC_OUT_W
);
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/mac_ser_baud_div.sv
// Bit-period divider: counts 0..CLK_DIV-1, pulses bit_tick on the wrap cycle.
// clear restarts the bit period so a new frame aligns to its accept edge.
module mac_ser_baud_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_tick
);

  localparam int unsigned DIV_W = 16;

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  assign bit_tick = (cnt_q == DIV_W'(CLK_DIV - 1));

  // Next count: wrap at the bit boundary or restart on clear.
  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (clear || bit_tick) cnt_d = '0;
  end

  // Divider counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mac_result_serializer.sv
// Serializes one MAC result per handshake onto a UART-style single-wire frame:
// start bit, data MSB-first, optional even parity (MAC_SER_PARITY_EN), stop bit.
module mac_result_serializer
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W  = MAC_OUT_W,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mac_result_serializer_if.slave  in_if,
  output logic                    sdo,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned CNT_W = (clog2(DATA_W) > 0) ? clog2(DATA_W) : 1;

  ser_state_e        state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              sdo_q, sdo_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef MAC_SER_PARITY_EN
  logic              parity_q, parity_d;
`endif

  logic accept;
  logic div_clear;
  logic bit_tick;

  mac_ser_baud_div #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (div_clear),
    .bit_tick (bit_tick)
  );

  assign in_if.din_ready = (state_q == IDLE);
  assign accept          = in_if.din_valid && (state_q == IDLE);

  assign sdo  = sdo_q;
  assign busy = busy_q;
  assign done = done_q;

  // Frame sequencing; sdo/busy/done are computed for the next cycle so the
  // registered outputs line up with the state they belong to.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    sdo_d     = sdo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    div_clear = 1'b0;
`ifdef MAC_SER_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      IDLE: begin
        sdo_d  = 1'b1;
        busy_d = 1'b0;
        if (accept) begin
          shreg_d   = in_if.din;
          bit_cnt_d = '0;
          div_clear = 1'b1;
          state_d   = START;
          sdo_d     = 1'b0;
          busy_d    = 1'b1;
`ifdef MAC_SER_PARITY_EN
          parity_d  = ^in_if.din;
`endif
        end
      end

      START: begin
        if (bit_tick) begin
          state_d = DATA;
          sdo_d   = shreg_q[DATA_W-1];
        end
      end

      DATA: begin
        if (bit_tick) begin
          shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            bit_cnt_d = '0;
`ifdef MAC_SER_PARITY_EN
            state_d   = PARITY;
            sdo_d     = parity_q;
`else
            state_d   = STOP;
            sdo_d     = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            sdo_d     = shreg_q[DATA_W-2];
          end
        end
      end

`ifdef MAC_SER_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          state_d = STOP;
          sdo_d   = 1'b1;
        end
      end
`endif

      STOP: begin
        if (bit_tick) begin
          state_d = IDLE;
          sdo_d   = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        sdo_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      sdo_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef MAC_SER_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      sdo_q     <= sdo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef MAC_SER_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_mac_result_serializer.sv
// Directed bench for mac_result_serializer: one DUT at CLK_DIV=4, one at CLK_DIV=1.
module tb_mac_result_serializer;
  import mac_pkg::*;

  localparam int unsigned DW = 18;
`ifdef MAC_SER_PARITY_EN
  localparam int unsigned NBITS = DW + 3;
`else
  localparam int unsigned NBITS = DW + 2;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mac_result_serializer_if #(.DATA_W(DW)) a_if ();
  mac_result_serializer_if #(.DATA_W(DW)) b_if ();

  logic sdo_a, busy_a, done_a;
  logic sdo_b, busy_b, done_b;

  mac_result_serializer #(.DATA_W(DW), .CLK_DIV(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .in_if (a_if.slave),
    .sdo   (sdo_a),
    .busy  (busy_a),
    .done  (done_a)
  );

  mac_result_serializer #(.DATA_W(DW), .CLK_DIV(1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .in_if (b_if.slave),
    .sdo   (sdo_b),
    .busy  (busy_b),
    .done  (done_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Present one word for a single accept edge on DUT A.
  task automatic send_a(input logic [DW-1:0] w);
    @(negedge clk);
    a_if.din       = w;
    a_if.din_valid = 1'b1;
    @(posedge clk);
    #1;
    a_if.din_valid = 1'b0;
    a_if.din       = '0;
  endtask

  // Walk a DUT A frame cycle by cycle from the first cycle after accept,
  // then the done cycle. bits are the hand-written data bits, MSB first.
  task automatic check_frame_a(input string name, input logic [DW-1:0] bits, input logic par);
    int  idx;
    logic e;
    for (int k = 1; k <= int'(NBITS) * 4; k++) begin
      @(negedge clk);
      idx = (k - 1) / 4;
      if (idx == 0)                    e = 1'b0;
      else if (idx <= int'(DW))        e = bits[int'(DW) - idx];
      else if (idx == int'(NBITS) - 1) e = 1'b1;
      else                             e = par;
      check_eq($sformatf("%s sdo c%0d", name, k), sdo_a, e);
      check_eq($sformatf("%s busy c%0d", name, k), busy_a, 1'b1);
      check_eq($sformatf("%s done c%0d", name, k), done_a, 1'b0);
      check_eq($sformatf("%s ready c%0d", name, k), a_if.din_ready, 1'b0);
    end
    @(negedge clk);
    check_eq($sformatf("%s done pulse", name), done_a, 1'b1);
    check_eq($sformatf("%s busy end", name), busy_a, 1'b0);
    check_eq($sformatf("%s sdo idle", name), sdo_a, 1'b1);
    check_eq($sformatf("%s ready end", name), a_if.din_ready, 1'b1);
  endtask

  logic [NBITS-1:0] pat_b;

  initial begin
    a_if.din = '0; a_if.din_valid = 1'b0;
    b_if.din = '0; b_if.din_valid = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst sdo", sdo_a, 1'b1);
    check_eq("rst busy", busy_a, 1'b0);
    check_eq("rst done", done_a, 1'b0);
    check_eq("rst ready", a_if.din_ready, 1'b1);
    check_eq("rst sdo b", sdo_b, 1'b1);
    check_eq("rst ready b", b_if.din_ready, 1'b1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic frame: 0x2A5C3 = 10_1010_0101_1100_0011, 9 ones
    send_a(18'h2A5C3);
    check_frame_a("basic", 18'b10_1010_0101_1100_0011, 1'b1);

`ifdef MAC_SER_PARITY_EN
    send_a(18'h00001);
    check_frame_a("par1", 18'b00_0000_0000_0000_0001, 1'b1);
    send_a(18'h00003);
    check_frame_a("par0", 18'b00_0000_0000_0000_0011, 1'b0);
`endif

    // Back-to-back: valid held, second word taken in the done cycle
    @(negedge clk);
    a_if.din       = 18'h3FFFF;
    a_if.din_valid = 1'b1;
    @(posedge clk);
    #1;
    a_if.din = 18'h00000;
    check_frame_a("b2b0", 18'b11_1111_1111_1111_1111, 1'b0);
    @(posedge clk);
    #1;
    a_if.din_valid = 1'b0;
    check_frame_a("b2b1", 18'b00_0000_0000_0000_0000, 1'b0);

    // Valid while busy is ignored
    repeat (2) @(negedge clk);
    send_a(18'h0F0F0);
    fork
      check_frame_a("ign", 18'b00_1111_0000_1111_0000, 1'b0);
      begin
        repeat (20) @(negedge clk);
        a_if.din       = 18'h12345;
        a_if.din_valid = 1'b1;
        @(negedge clk);
        a_if.din_valid = 1'b0;
        a_if.din       = '0;
      end
    join
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_eq($sformatf("ign idle busy %0d", k), busy_a, 1'b0);
      check_eq($sformatf("ign idle sdo %0d", k), sdo_a, 1'b1);
      check_eq($sformatf("ign idle done %0d", k), done_a, 1'b0);
    end

    // Reset 30 cycles into a frame
    send_a(18'h15555);
    repeat (30) @(negedge clk);
    check_eq("midrst pre busy", busy_a, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst sdo", sdo_a, 1'b1);
    check_eq("midrst busy", busy_a, 1'b0);
    check_eq("midrst ready", a_if.din_ready, 1'b1);
    check_eq("midrst done", done_a, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_a(18'h2A5C3);
    check_frame_a("postrst", 18'b10_1010_0101_1100_0011, 1'b1);

    // CLK_DIV = 1, 0x20001: one bit per cycle
`ifdef MAC_SER_PARITY_EN
    pat_b = {2'b01, 16'h0000, 1'b1, 1'b0, 1'b1};
`else
    pat_b = {2'b01, 16'h0000, 1'b1, 1'b1};
`endif
    @(negedge clk);
    b_if.din       = 18'h20001;
    b_if.din_valid = 1'b1;
    @(posedge clk);
    #1;
    b_if.din_valid = 1'b0;
    b_if.din       = '0;
    for (int k = 1; k <= int'(NBITS); k++) begin
      @(negedge clk);
      check_eq($sformatf("div1 sdo c%0d", k), sdo_b, pat_b[int'(NBITS) - k]);
      check_eq($sformatf("div1 busy c%0d", k), busy_b, 1'b1);
      check_eq($sformatf("div1 done c%0d", k), done_b, 1'b0);
    end
    @(negedge clk);
    check_eq("div1 done pulse", done_b, 1'b1);
    check_eq("div1 busy end", busy_b, 1'b0);
    check_eq("div1 sdo idle", sdo_b, 1'b1);
    @(negedge clk);
    check_eq("div1 done once", done_b, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
